ece429_mem_boot_arbiter: RTL and testbench

- Owns the single ECE429 memory port. Sequences the boot load: pulses the SREC parser's enable, then routes parser writes to memory until the parser reports done or error.
- After a successful load, it serves a fetch requester (CPU fetch / readback) and expands burst requests into word-sized memory reads.
- It replaces the ad-hoc done-based muxing on the memory port.

---
 rtl/ece429_pkg.sv | 40 ++++
 rtl/ece429_burst_gen.sv | 84 ++++++++
 rtl/ece429_mem_boot_arbiter.sv | 157 +++++++++++++++
 tb/tb_ece429_mem_boot_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ece429_pkg.sv
// Shared definitions for the ECE429 memory boot arbiter.
// Holds the arbiter state encoding, memory access-size codes, the
// fetch-size to beat-count mapping, read/write codes and the word stride.
package ece429_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READY = 3'd3,
    ST_BURST = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // Memory access-size code used for word reads.
  localparam logic [1:0] ACCESS_WORD = 2'b00;

  // Fetch burst-size codes.
  localparam logic [1:0] SIZE_1W  = 2'b00;
  localparam logic [1:0] SIZE_4W  = 2'b01;
  localparam logic [1:0] SIZE_8W  = 2'b10;
  localparam logic [1:0] SIZE_16W = 2'b11;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  function automatic logic [4:0] size_to_beats(input logic [1:0] size);
    logic [4:0] beats;
    case (size)
      SIZE_1W:  beats = 5'd1;
      SIZE_4W:  beats = 5'd4;
      SIZE_8W:  beats = 5'd8;
      default:  beats = 5'd16;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ece429_burst_gen.sv
// Burst address generator and read-return pipeline.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   start             - issue beat 0 of a new burst at start_addr this cycle
//   start_addr        - word-aligned base address of the burst
//   start_beats       - total number of beats in the burst (1..16)
//   step              - issue the next beat of the current burst this cycle
//   beat_addr         - address of the beat issued this cycle (0 if none)
//   beat_last         - the beat issued this cycle is the final one
//   rvalid, rlast     - issued beats delayed by READ_LATENCY cycles
module ece429_burst_gen
  import ece429_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [4:0]  start_beats,
  input  logic        step,
  output logic [31:0] beat_addr,
  output logic        beat_last,
  output logic        rvalid,
  output logic        rlast
);

  logic [31:0]             addr_q, addr_d;
  logic [4:0]              remain_q, remain_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] last_q, last_d;
  logic                    issue;

  assign issue = start | step;

  // remain_q counts beats still to be issued after the last one sent.
  always_comb begin
    beat_addr = '0;
    beat_last = 1'b0;
    addr_d    = addr_q;
    remain_d  = remain_q;
    if (start) begin
      beat_addr = start_addr;
      beat_last = (start_beats == 5'd1);
      addr_d    = start_addr;
      remain_d  = start_beats - 5'd1;
    end else if (step) begin
      // 32-bit add wraps 0xFFFFFFFC to 0x00000000 naturally.
      beat_addr = addr_q + WORD_STRIDE;
      beat_last = (remain_q == 5'd1);
      addr_d    = addr_q + WORD_STRIDE;
      remain_d  = remain_q - 5'd1;
    end
  end

  always_comb begin
    vld_d     = '0;
    last_d    = '0;
    vld_d[0]  = issue;
    last_d[0] = issue & beat_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      remain_q <= '0;
      vld_q    <= '0;
      last_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
    end
  end

  assign rvalid = vld_q[READ_LATENCY-1];
  assign rlast  = last_q[READ_LATENCY-1];

endmodule

// File: rtl/ece429_mem_boot_arbiter.sv
// Owner of the single ECE429 memory port. Sequences the boot load through
// the SREC parser, then serves word/burst fetch requests.
// Ports:
//   clock, reset                    - clock, asynchronous active-high reset
//   boot_start                      - pulse that starts the boot load
//   parse_enable                    - one-cycle enable pulse to the parser
//   parse_addr/data/access_size     - parser write request (routed in LOAD)
//   parse_done, parse_error         - parser completion status
//   fetch_req/addr/size, fetch_gnt  - fetch request handshake
//   fetch_rdata/rvalid/rlast        - fetch read return
//   mem_address/datain/access_size/r_w, mem_dataout - memory port
//   boot_done, boot_error           - sticky boot status
module ece429_mem_boot_arbiter
  import ece429_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 32'd1000000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        boot_start,
  output logic        parse_enable,
  input  logic [31:0] parse_addr,
  input  logic [31:0] parse_data,
  input  logic [1:0]  parse_access_size,
  input  logic        parse_done,
  input  logic        parse_error,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic [1:0]  fetch_size,
  output logic        fetch_gnt,
  output logic [31:0] fetch_rdata,
  output logic        fetch_rvalid,
  output logic        fetch_rlast,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic [1:0]  mem_access_size,
  output logic        mem_r_w,
  input  logic [31:0] mem_dataout,
  output logic        boot_done,
  output logic        boot_error
);

  state_t      state_q, state_d;
  logic [31:0] timeout_q, timeout_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        burst_start;
  logic        burst_step;
  logic [4:0]  req_beats;
  logic [31:0] req_addr;
  logic [31:0] beat_addr;
  logic        beat_last;
  logic        rvalid;
  logic        rlast;

  assign req_beats   = size_to_beats(fetch_size);
  assign req_addr    = fetch_addr & ~32'h3;
  assign burst_start = (state_q == ST_READY) && fetch_req;
  assign burst_step  = (state_q == ST_BURST);

  ece429_burst_gen #(
    .READ_LATENCY(READ_LATENCY)
  ) u_burst_gen (
    .clock       (clock),
    .reset       (reset),
    .start       (burst_start),
    .start_addr  (req_addr),
    .start_beats (req_beats),
    .step        (burst_step),
    .beat_addr   (beat_addr),
    .beat_last   (beat_last),
    .rvalid      (rvalid),
    .rlast       (rlast)
  );

  always_comb begin
    state_d         = state_q;
    timeout_d       = timeout_q;
    done_d          = done_q;
    err_d           = err_q;
    parse_enable    = 1'b0;
    fetch_gnt       = 1'b0;
    mem_address     = '0;
    mem_datain      = '0;
    mem_access_size = ACCESS_WORD;
    mem_r_w         = MEM_READ;

    case (state_q)
      ST_IDLE: begin
        if (boot_start) state_d = ST_START;
      end
      ST_START: begin
        parse_enable = 1'b1;
        timeout_d    = '0;
        state_d      = ST_LOAD;
      end
      ST_LOAD: begin
        mem_address     = parse_addr;
        mem_datain      = parse_data;
        mem_access_size = parse_access_size;
        mem_r_w         = MEM_WRITE;
        timeout_d       = timeout_q + 32'd1;
        // Error has priority over done; timeout only when neither arrives.
        if (parse_error) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else if (parse_done) begin
          done_d  = 1'b1;
          state_d = ST_READY;
        end else if ((LOAD_TIMEOUT != 0) && (timeout_d == LOAD_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_READY: begin
        if (fetch_req) begin
          fetch_gnt   = 1'b1;
          mem_address = beat_addr;
          if (req_beats > 5'd1) state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        mem_address = beat_addr;
        if (beat_last) state_d = ST_READY;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timeout_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign fetch_rvalid = rvalid;
  assign fetch_rlast  = rlast;
  assign fetch_rdata  = rvalid ? mem_dataout : '0;
  assign boot_done    = done_q;
  assign boot_error   = err_q;

endmodule

// File: tb/tb_ece429_mem_boot_arbiter.sv
module tb_ece429_mem_boot_arbiter;

  localparam logic [31:0] MEMK = 32'h5A5A_0000;

  logic        clock;
  logic        reset;
  logic        boot_start;
  logic        parse_enable;
  logic [31:0] parse_addr;
  logic [31:0] parse_data;
  logic [1:0]  parse_access_size;
  logic        parse_done;
  logic        parse_error;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [1:0]  fetch_size;
  logic        fetch_gnt;
  logic [31:0] fetch_rdata;
  logic        fetch_rvalid;
  logic        fetch_rlast;
  logic [31:0] mem_address;
  logic [31:0] mem_datain;
  logic [1:0]  mem_access_size;
  logic        mem_r_w;
  logic [31:0] mem_dataout;
  logic        boot_done;
  logic        boot_error;

  int vec_cnt = 0;
  int err_cnt = 0;

  ece429_mem_boot_arbiter #(
    .LOAD_TIMEOUT(20),
    .READ_LATENCY(1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .boot_start        (boot_start),
    .parse_enable      (parse_enable),
    .parse_addr        (parse_addr),
    .parse_data        (parse_data),
    .parse_access_size (parse_access_size),
    .parse_done        (parse_done),
    .parse_error       (parse_error),
    .fetch_req         (fetch_req),
    .fetch_addr        (fetch_addr),
    .fetch_size        (fetch_size),
    .fetch_gnt         (fetch_gnt),
    .fetch_rdata       (fetch_rdata),
    .fetch_rvalid      (fetch_rvalid),
    .fetch_rlast       (fetch_rlast),
    .mem_address       (mem_address),
    .mem_datain        (mem_datain),
    .mem_access_size   (mem_access_size),
    .mem_r_w           (mem_r_w),
    .mem_dataout       (mem_dataout),
    .boot_done         (boot_done),
    .boot_error        (boot_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle read memory: contents are the address xor a fixed key.
  initial mem_dataout = '0;
  always @(posedge clock) mem_dataout <= mem_address ^ MEMK;

  function automatic logic [135:0] all_outs();
    return {parse_enable, fetch_gnt, fetch_rdata, fetch_rvalid, fetch_rlast,
            mem_address, mem_datain, mem_access_size, mem_r_w, boot_done,
            boot_error, 29'd0};
  endfunction

  task automatic clear_inputs();
    boot_start        = 1'b0;
    parse_addr        = '0;
    parse_data        = '0;
    parse_access_size = '0;
    parse_done        = 1'b0;
    parse_error       = 1'b0;
    fetch_req         = 1'b0;
    fetch_addr        = '0;
    fetch_size        = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first READY cycle.
  task automatic do_boot();
    boot_start = 1'b1;
    @(negedge clock);
    boot_start = 1'b0;
    @(negedge clock);
    parse_done = 1'b1;
    @(negedge clock);
    parse_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #1;
    vec_cnt++;
    if (all_outs() !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_boot();
    boot_start = 1'b1;
    #1;
    vec_cnt++;
    if (parse_enable !== 1'b0) begin
      err_cnt++;
      $display("FAIL boot_pe_idle got %b want 0", parse_enable);
    end
    @(negedge clock);
    boot_start = 1'b0;
    #1;
    vec_cnt++;
    if (parse_enable !== 1'b1) begin
      err_cnt++;
      $display("FAIL boot_pe_start got %b want 1", parse_enable);
    end
    @(negedge clock);
    parse_addr = 32'h8002_0000; parse_data = 32'hDEAD_BEEF; parse_access_size = 2'b10;
    #1;
    vec_cnt++;
    if ({parse_enable, mem_r_w, mem_address, mem_datain, mem_access_size} !==
        {1'b0, 1'b1, 32'h8002_0000, 32'hDEAD_BEEF, 2'b10}) begin
      err_cnt++;
      $display("FAIL load_port got pe=%b rw=%b a=%h d=%h s=%b want 0 1 80020000 deadbeef 10",
               parse_enable, mem_r_w, mem_address, mem_datain, mem_access_size);
    end
    @(negedge clock);
    parse_addr = 32'h8002_0004; parse_done = 1'b1;
    #1;
    vec_cnt++;
    if ({mem_r_w, mem_address, boot_done} !== {1'b1, 32'h8002_0004, 1'b0}) begin
      err_cnt++;
      $display("FAIL load_track got rw=%b a=%h done=%b want 1 80020004 0",
               mem_r_w, mem_address, boot_done);
    end
    @(negedge clock);
    parse_done = 1'b0;
    #1;
    vec_cnt++;
    if ({boot_done, boot_error, mem_r_w, mem_address, mem_datain} !== {3'b100, 64'd0}) begin
      err_cnt++;
      $display("FAIL boot_done got done=%b err=%b rw=%b a=%h d=%h want 1 0 0 0 0",
               boot_done, boot_error, mem_r_w, mem_address, mem_datain);
    end
  endtask

  task automatic test_error();
    do_reset();
    boot_start = 1'b1;
    @(negedge clock);
    boot_start = 1'b0;
    @(negedge clock);
    parse_done = 1'b1; parse_error = 1'b1;
    @(negedge clock);
    parse_done = 1'b0; parse_error = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h8002_0000; fetch_size = 2'b00;
    #1;
    vec_cnt++;
    if ({boot_error, boot_done} !== 2'b10) begin
      err_cnt++;
      $display("FAIL error_state got err=%b done=%b want 1 0", boot_error, boot_done);
    end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if ({fetch_gnt, mem_address, boot_error} !== {1'b0, 32'd0, 1'b1}) begin
        err_cnt++;
        $display("FAIL error_no_gnt cycle %0d got gnt=%b a=%h err=%b want 0 0 1",
                 i, fetch_gnt, mem_address, boot_error);
      end
      @(negedge clock);
      #1;
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    do_boot();
    fetch_req = 1'b1; fetch_addr = 32'h8002_0003; fetch_size = 2'b00;
    #1;
    vec_cnt++;
    if ({fetch_gnt, mem_address, mem_r_w, fetch_rvalid} !== {1'b1, 32'h8002_0000, 2'b00}) begin
      err_cnt++;
      $display("FAIL single_issue got gnt=%b a=%h rw=%b rv=%b want 1 80020000 0 0",
               fetch_gnt, mem_address, mem_r_w, fetch_rvalid);
    end
    @(negedge clock);
    // Back-to-back single: a second request in the very next cycle.
    fetch_addr = 32'h0000_0104;
    #1;
    vec_cnt++;
    if ({fetch_gnt, mem_address, fetch_rvalid, fetch_rlast, fetch_rdata} !==
        {1'b1, 32'h0000_0104, 2'b11, 32'h8002_0000 ^ MEMK}) begin
      err_cnt++;
      $display("FAIL single_return got gnt=%b a=%h rv=%b rl=%b d=%h want 1 00000104 1 1 %h",
               fetch_gnt, mem_address, fetch_rvalid, fetch_rlast, fetch_rdata,
               32'h8002_0000 ^ MEMK);
    end
    @(negedge clock);
    fetch_req = 1'b0;
    #1;
    vec_cnt++;
    if ({fetch_gnt, fetch_rvalid, fetch_rlast, fetch_rdata} !==
        {3'b011, 32'h0000_0104 ^ MEMK}) begin
      err_cnt++;
      $display("FAIL b2b_return got gnt=%b rv=%b rl=%b d=%h want 0 1 1 %h",
               fetch_gnt, fetch_rvalid, fetch_rlast, fetch_rdata, 32'h0000_0104 ^ MEMK);
    end
    @(negedge clock);
    #1;
    vec_cnt++;
    if ({fetch_rvalid, fetch_rlast, fetch_rdata} !== 34'd0) begin
      err_cnt++;
      $display("FAIL single_idle got rv=%b rl=%b d=%h want 0 0 0",
               fetch_rvalid, fetch_rlast, fetch_rdata);
    end
  endtask

  task automatic test_burst16();
    logic [31:0] base;
    logic [31:0] exp_a;
    logic        exp_g;
    base = 32'h8002_0000;
    fetch_req = 1'b1; fetch_addr = base; fetch_size = 2'b11;
    for (int i = 0; i < 17; i++) begin
      #1;
      exp_g = (i == 0) || (i == 16);
      exp_a = (i < 16) ? base + 32'(4 * i) : 32'h8003_0000;
      vec_cnt++;
      if ({fetch_gnt, mem_address} !== {exp_g, exp_a}) begin
        err_cnt++;
        $display("FAIL burst_issue beat %0d got gnt=%b a=%h want %b %h",
                 i, fetch_gnt, mem_address, exp_g, exp_a);
      end
      if (i > 0) begin
        vec_cnt++;
        if ({fetch_rvalid, fetch_rlast, fetch_rdata} !==
            {1'b1, (i == 16), (base + 32'(4 * (i - 1))) ^ MEMK}) begin
          err_cnt++;
          $display("FAIL burst_return beat %0d got rv=%b rl=%b d=%h want 1 %b %h",
                   i - 1, fetch_rvalid, fetch_rlast, fetch_rdata, (i == 16),
                   (base + 32'(4 * (i - 1))) ^ MEMK);
        end
      end
      @(negedge clock);
      if (i == 0) begin
        fetch_addr = 32'h8003_0000; fetch_size = 2'b00;
      end
      if (i == 16) fetch_req = 1'b0;
    end
    #1;
    vec_cnt++;
    if ({fetch_gnt, fetch_rvalid, fetch_rlast, fetch_rdata} !==
        {3'b011, 32'h8003_0000 ^ MEMK}) begin
      err_cnt++;
      $display("FAIL held_req_return got gnt=%b rv=%b rl=%b d=%h want 0 1 1 %h",
               fetch_gnt, fetch_rvalid, fetch_rlast, fetch_rdata, 32'h8003_0000 ^ MEMK);
    end
    @(negedge clock);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
    fetch_req = 1'b1; fetch_addr = 32'hFFFF_FFF8; fetch_size = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) begin
        vec_cnt++;
        if (mem_address !== exp_a[i]) begin
          err_cnt++;
          $display("FAIL wrap_addr beat %0d got %h want %h", i, mem_address, exp_a[i]);
        end
      end
      if (i > 0) begin
        vec_cnt++;
        if ({fetch_rvalid, fetch_rlast, fetch_rdata} !== {1'b1, (i == 4), exp_a[i-1] ^ MEMK}) begin
          err_cnt++;
          $display("FAIL wrap_return beat %0d got rv=%b rl=%b d=%h want 1 %b %h",
                   i - 1, fetch_rvalid, fetch_rlast, fetch_rdata, (i == 4), exp_a[i-1] ^ MEMK);
        end
      end
      @(negedge clock);
      if (i == 0) fetch_req = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    boot_start = 1'b1;
    @(negedge clock);
    boot_start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      #1;
      vec_cnt++;
      if ({mem_r_w, boot_error} !== 2'b10) begin
        err_cnt++;
        $display("FAIL timeout_load cycle %0d got rw=%b err=%b want 1 0", i, mem_r_w, boot_error);
      end
      @(negedge clock);
    end
    #1;
    vec_cnt++;
    if ({mem_r_w, boot_error, boot_done} !== 3'b010) begin
      err_cnt++;
      $display("FAIL timeout_error got rw=%b err=%b done=%b want 0 1 0",
               mem_r_w, boot_error, boot_done);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    do_boot();
    fetch_req = 1'b1; fetch_addr = 32'h8002_0000; fetch_size = 2'b11;
    @(negedge clock);
    fetch_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (all_outs() !== '0) begin
      err_cnt++;
      $display("FAIL async_reset_outputs got %h want 0", all_outs());
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++;
      if ({fetch_rvalid, mem_address, boot_done} !== 34'd0) begin
        err_cnt++;
        $display("FAIL post_reset cycle %0d got rv=%b a=%h done=%b want 0 0 0",
                 i, fetch_rvalid, mem_address, boot_done);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vec_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_boot();
    test_error();
    test_single();
    test_burst16();
    test_wrap();
    test_timeout();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
